// File: rtl/spi_draw_queue_if.sv
// Renderer-side draw-entry handshake bundle for spi_draw_queue.
interface spi_draw_queue_if;
    logic        draw_valid;
    logic        draw_ready;
    logic [7:0]  draw_id;
    logic [15:0] draw_x;
    logic [15:0] draw_y;
    logic [7:0]  draw_flags;

    modport master (
        output draw_valid, draw_id, draw_x, draw_y, draw_flags,
        input  draw_ready
    );

    modport slave (
        input  draw_valid, draw_id, draw_x, draw_y, draw_flags,
        output draw_ready
    );
endinterface

// File: rtl/spi_draw_queue.sv
// SPI byte-stream parser: assembles draw-sprite commands into a FWFT entry FIFO.
// Define SPI_DRAW_CLIP_EN to discard entries outside SCREEN_W x SCREEN_H.
module spi_draw_queue #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  CMD_SAVE   = 8'h01,
    parameter logic [7:0]  CMD_DRAW   = 8'h02,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        cs,
    input  logic                        byte_strobe,
    input  logic [7:0]                  byte_data,
    spi_draw_queue_if.master            draw,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic                        busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DRAW, SKIP} state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  flags;
    } entry_t;

    logic   strobe_s1, strobe_s2, strobe_s3;
    logic   cs_s1, cs_s2;
    logic   accept;
    state_t state;
    logic [2:0]  idx;
    logic [9:0]  cnt;
    logic [7:0]  ent_id, ent_flags;
    logic [15:0] ent_x, ent_y;
    logic   push_pending;
    logic   in_bounds;

    entry_t mem [FIFO_DEPTH];
    entry_t head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic   full, valid, pop, push, wr_en, drop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_s1 <= 1'b0;
            strobe_s2 <= 1'b0;
            strobe_s3 <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
        end else begin
            strobe_s1 <= byte_strobe;
            strobe_s2 <= strobe_s1;
            strobe_s3 <= strobe_s2;
            cs_s1     <= cs;
            cs_s2     <= cs_s1;
        end
    end

    assign accept = strobe_s2 & ~strobe_s3;

    // Byte is processed before a coincident cs rise forces IDLE, so a completing
    // 6th draw byte still raises push_pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            ent_id       <= '0;
            ent_x        <= '0;
            ent_y        <= '0;
            ent_flags    <= '0;
            push_pending <= 1'b0;
        end else begin
            push_pending <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (byte_data == CMD_DRAW) begin
                            state <= DRAW;
                            idx   <= '0;
                        end else if (byte_data == CMD_SAVE) begin
                            state <= SKIP;
                            cnt   <= 10'd513;
                        end
                    end
                    DRAW: begin
                        idx <= idx + 3'd1;
                        case (idx)
                            3'd0: ent_id      <= byte_data;
                            3'd1: ent_x[15:8] <= byte_data;
                            3'd2: ent_x[7:0]  <= byte_data;
                            3'd3: ent_y[15:8] <= byte_data;
                            3'd4: ent_y[7:0]  <= byte_data;
                            default: begin
                                ent_flags    <= byte_data;
                                push_pending <= 1'b1;
                                state        <= IDLE;
                            end
                        endcase
                    end
                    SKIP: begin
                        cnt <= cnt - 10'd1;
                        if (cnt == 10'd1) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
            if (cs_s2) state <= IDLE;
        end
    end

    assign busy = (state != IDLE);

`ifdef SPI_DRAW_CLIP_EN
    assign in_bounds = ({16'd0, ent_x} < SCREEN_W) && ({16'd0, ent_y} < SCREEN_H);
`else
    logic [31:0] unused_screen;
    assign unused_screen = SCREEN_W ^ SCREEN_H;
    assign in_bounds     = 1'b1;
`endif

    assign full  = (fifo_count == CW'(FIFO_DEPTH));
    assign valid = (fifo_count != '0);
    assign pop   = valid & draw.draw_ready;
    assign push  = push_pending & in_bounds;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= '{id: ent_id, x: ent_x, y: ent_y, flags: ent_flags};
    end

    assign head            = mem[rd_ptr];
    assign draw.draw_valid = valid;
    assign draw.draw_id    = valid ? head.id    : '0;
    assign draw.draw_x     = valid ? head.x     : '0;
    assign draw.draw_y     = valid ? head.y     : '0;
    assign draw.draw_flags = valid ? head.flags : '0;
endmodule

// File: tb/tb_spi_draw_queue.sv
// Self-checking bench for spi_draw_queue: table vectors, corner sequences and
// randomized command streams checked against a byte-level queue model.
`timescale 1ns/1ps
module tb_spi_draw_queue;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       cs;
    logic       byte_strobe;
    logic [7:0] byte_data;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       overflow_clr;
    logic       busy;

    spi_draw_queue_if dif ();

    spi_draw_queue #(.FIFO_DEPTH(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cs           (cs),
        .byte_strobe  (byte_strobe),
        .byte_data    (byte_data),
        .draw         (dif),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .busy         (busy)
    );

    always #5 clock = ~clock;

`ifdef SPI_DRAW_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef struct {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  flags;
    } ent_t;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  flags;
        bit          off_screen;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: bytes left to skip, collected draw payload, expected queue.
    int         skip_left = 0;
    bit         in_draw   = 1'b0;
    logic [7:0] payload[$];
    ent_t       exp_q[$];
    bit         model_ov  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b);
        ent_t e;
        if (skip_left > 0) begin
            skip_left--;
        end else if (in_draw) begin
            payload.push_back(b);
            if (payload.size() == 6) begin
                in_draw = 1'b0;
                e.id    = payload[0];
                e.x     = {payload[1], payload[2]};
                e.y     = {payload[3], payload[4]};
                e.flags = payload[5];
                if (!CLIP || (e.x < 16'd640 && e.y < 16'd480)) begin
                    if (exp_q.size() >= 16) model_ov = 1'b1;
                    else exp_q.push_back(e);
                end
            end
        end else if (b == 8'h02) begin
            in_draw = 1'b1;
            payload.delete();
        end else if (b == 8'h01) begin
            skip_left = 513;
        end
    endfunction

    function automatic void model_cs_high();
        in_draw   = 1'b0;
        skip_left = 0;
    endfunction

    // One byte at SCK = clock/8; optionally pulses draw_ready on the push cycle
    // of a completing byte, or raises cs together with the strobe.
    task automatic send_byte(input logic [7:0] b, input bit pulse_ready, input bit raise_cs);
        @(negedge clock);
        byte_data   = b;
        byte_strobe = 1'b1;
        if (raise_cs) cs = 1'b1;
        repeat (3) @(negedge clock);
        if (pulse_ready) begin
            if (exp_q.size() > 0) check("pp_head_id", 32'(dif.draw_id), 32'(exp_q[0].id));
            dif.draw_ready = 1'b1;
        end
        @(negedge clock);
        dif.draw_ready = 1'b0;
        byte_strobe    = 1'b0;
        if (pulse_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        model_byte(b);
        if (raise_cs) model_cs_high();
        repeat (4) @(negedge clock);
    endtask

    task automatic send_draw(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                             input logic [7:0] flags, input bit pulse_last);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(id, 1'b0, 1'b0);
        send_byte(x[15:8], 1'b0, 1'b0);
        send_byte(x[7:0], 1'b0, 1'b0);
        send_byte(y[15:8], 1'b0, 1'b0);
        send_byte(y[7:0], 1'b0, 1'b0);
        send_byte(flags, pulse_last, 1'b0);
    endtask

    task automatic cs_toggle();
        @(negedge clock);
        cs = 1'b1;
        model_cs_high();
        repeat (4) @(negedge clock);
        cs = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic drain(input string tag);
        ent_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(dif.draw_valid), 1);
            check({tag, "_id"},    32'(dif.draw_id),    32'(e.id));
            check({tag, "_x"},     32'(dif.draw_x),     32'(e.x));
            check({tag, "_y"},     32'(dif.draw_y),     32'(e.y));
            check({tag, "_flags"}, 32'(dif.draw_flags), 32'(e.flags));
            dif.draw_ready = 1'b1;
            @(negedge clock);
            dif.draw_ready = 1'b0;
        end
        check({tag, "_empty"}, 32'(dif.draw_valid), 0);
        check({tag, "_count0"}, 32'(fifo_count), 0);
    endtask

    task automatic clear_overflow();
        @(negedge clock);
        overflow_clr = 1'b1;
        @(negedge clock);
        overflow_clr = 1'b0;
        model_ov     = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   exp_n;
        vecs[0] = '{64'h0205012C00F00300, 7, 8'h05, 16'd300,  16'd240,  8'h03, 1'b0};
        vecs[1] = '{64'hAA02FFFFFFFFFFFF, 8, 8'hFF, 16'hFFFF, 16'hFFFF, 8'hFF, 1'b1};
        vecs[2] = '{64'h0201028000100000, 7, 8'h01, 16'd640,  16'd16,   8'h00, 1'b1};
        vecs[3] = '{64'h0201027F00100000, 7, 8'h01, 16'd639,  16'd16,   8'h00, 1'b0};
        vecs[4] = '{64'h770203000101DF01, 8, 8'h03, 16'd1,    16'd479,  8'h01, 1'b0};
        vecs[5] = '{64'h02040000_01E05A00, 7, 8'h04, 16'd0,   16'd480,  8'h5A, 1'b1};

        reset_n        = 1'b0;
        cs             = 1'b1;
        byte_strobe    = 1'b0;
        byte_data      = 8'h00;
        dif.draw_ready = 1'b0;
        overflow_clr   = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(dif.draw_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ovf",   32'(overflow), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_id",    32'(dif.draw_id), 0);
        check("rst_x",     32'(dif.draw_x), 0);
        reset_n = 1'b1;
        @(negedge clock);
        cs = 1'b0;
        repeat (4) @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            logic [63:0] bv;
            bv = vecs[i].bytes;
            for (int k = 0; k < vecs[i].n; k++) send_byte(bv[63-8*k -: 8], 1'b0, 1'b0);
            exp_n = (CLIP && vecs[i].off_screen) ? 0 : 1;
            check("vec_count", 32'(fifo_count), 32'(exp_n));
            check("vec_valid", 32'(dif.draw_valid), 32'(exp_n));
            check("vec_busy",  32'(busy), 0);
            if (exp_n == 1) begin
                check("vec_id",    32'(dif.draw_id),    32'(vecs[i].id));
                check("vec_x",     32'(dif.draw_x),     32'(vecs[i].x));
                check("vec_y",     32'(dif.draw_y),     32'(vecs[i].y));
                check("vec_flags", 32'(dif.draw_flags), 32'(vecs[i].flags));
            end
            drain("vec");
        end

        // Save command: 513 payload bytes of 0x02 must be skipped.
        send_byte(8'h01, 1'b0, 1'b0);
        for (int k = 0; k < 512; k++) send_byte(8'h02, 1'b0, 1'b0);
        check("skip_busy_before_last", 32'(busy), 1);
        send_byte(8'h02, 1'b0, 1'b0);
        check("skip_busy_after_last", 32'(busy), 0);
        check("skip_count", 32'(fifo_count), 0);
        send_draw(8'h07, 16'd16, 16'd32, 8'h00, 1'b0);
        check("skip_next_count", 32'(fifo_count), 1);
        check("skip_next_id", 32'(dif.draw_id), 32'h07);
        check("skip_next_x",  32'(dif.draw_x), 16);
        check("skip_next_y",  32'(dif.draw_y), 32);
        drain("skip");

        // Chip-select abort mid-command discards the partial entry.
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        check("abort_busy", 32'(busy), 1);
        cs_toggle();
        check("abort_idle", 32'(busy), 0);
        send_draw(8'h09, 16'd1, 16'd2, 8'h01, 1'b0);
        check("abort_count", 32'(fifo_count), 1);
        check("abort_id", 32'(dif.draw_id), 32'h09);
        check("abort_x",  32'(dif.draw_x), 1);
        check("abort_y",  32'(dif.draw_y), 2);
        drain("abort");

        // cs rise coincident with the 6th payload byte still pushes.
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h06, 1'b0, 1'b0);
        send_byte(8'h0C, 1'b0, 1'b1);
        check("csrace_count", 32'(fifo_count), 1);
        check("csrace_busy",  32'(busy), 0);
        check("csrace_id",    32'(dif.draw_id), 32'hAA);
        check("csrace_flags", 32'(dif.draw_flags), 32'h0C);
        cs = 1'b0;
        repeat (4) @(negedge clock);
        drain("csrace");

        // 17 commands into a 16-deep FIFO with no consumer.
        for (int i = 0; i < 17; i++)
            send_draw(8'(8'h10 + i), 16'(i * 3), 16'(i * 5), 8'(~i), 1'b0);
        check("ovf_count", 32'(fifo_count), 16);
        check("ovf_flag",  32'(overflow), 1);
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 1);
        clear_overflow();

        // Simultaneous push and pop while full.
        for (int i = 0; i < 16; i++)
            send_draw(8'(8'h40 + i), 16'(i), 16'(i + 100), 8'(i), 1'b0);
        check("pp_full", 32'(fifo_count), 16);
        send_draw(8'h99, 16'd7, 16'd8, 8'h33, 1'b1);
        check("pp_count", 32'(fifo_count), 16);
        check("pp_ovf",   32'(overflow), 0);
        drain("pp");

        // Randomized streams checked against the queue model.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(4, 20);
            for (int c = 0; c < n; c++) begin
                int sel;
                sel = $urandom_range(0, 9);
                if (sel < 7) begin
                    send_draw(8'($urandom), 16'($urandom_range(0, 1023)),
                              16'($urandom_range(0, 700)), 8'($urandom), 1'b0);
                end else if (sel == 7) begin
                    send_byte(8'($urandom_range(3, 255)), 1'b0, 1'b0);
                end else if (sel == 8 || r != 0) begin
                    int k;
                    k = $urandom_range(0, 5);
                    send_byte(8'h02, 1'b0, 1'b0);
                    for (int j = 0; j < k; j++) send_byte(8'($urandom), 1'b0, 1'b0);
                    cs_toggle();
                end else begin
                    send_byte(8'h01, 1'b0, 1'b0);
                    for (int j = 0; j < 513; j++) send_byte(8'($urandom), 1'b0, 1'b0);
                end
            end
            check("rnd_count", 32'(fifo_count), 32'(exp_q.size()));
            check("rnd_ovf",   32'(overflow), 32'(model_ov));
            check("rnd_busy",  32'(busy), 32'(in_draw || skip_left > 0));
            if (in_draw || skip_left > 0) cs_toggle();
            drain("rnd");
            clear_overflow();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
